barrier_master: RTL and testbench

//  Synchronization-master end of the barrier protocol. Receives ACCOUNT messages from tile barrier cores via the NI.

---
 rtl/barrier_master_pkg.sv | 51 +++++
 rtl/barrier_master_if.sv | 33 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/barrier_master.sv | 126 ++++++++++++
 tb/tb_barrier_master.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrier_master_pkg.sv
// barrier_master_pkg: shared barrier message, table and release-queue types.
// Also provides the idx_to_oh helper and default TILE_COUNT / table size.
`ifndef TILE_COUNT
`define TILE_COUNT 4
`endif
`ifndef BARRIER_NUMB_FOR_TILE
`define BARRIER_NUMB_FOR_TILE 8
`endif

package barrier_master_pkg;

  localparam int TILE_COUNT = `TILE_COUNT;
  localparam int TILE_W     = $clog2(TILE_COUNT);
  localparam int BARRIER_W  = 8;
  localparam int CNT_W      = 6;

  typedef logic [BARRIER_W-1:0]  barrier_t;
  typedef logic [CNT_W-1:0]      cnt_barrier_t;
  typedef logic [TILE_W-1:0]     tile_id_t;
  typedef logic [TILE_COUNT-1:0] tile_mask_t;

  typedef struct packed {
    tile_id_t     tile_id_source;
    barrier_t     id_barrier;
    cnt_barrier_t cnt_setup;
  } sync_account_message_t;

  typedef struct packed {
    barrier_t id_barrier;
  } sync_release_message_t;

  typedef struct packed {
    logic         active;
    cnt_barrier_t remaining;
    cnt_barrier_t setup;
    tile_mask_t   tile_mask;
  } barrier_master_entry_t;

  typedef struct packed {
    barrier_t   id_barrier;
    tile_mask_t tile_mask;
  } release_fifo_entry_t;

  function automatic tile_mask_t idx_to_oh(input tile_id_t idx);
    tile_mask_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/barrier_master_if.sv
// barrier_master_if: NI <-> barrier master ACCOUNT in / RELEASE out bundle.
// master: barrier_master side; slave: network-interface side.
interface barrier_master_if;
  import barrier_master_pkg::*;

  logic                  n2c_account_valid;
  sync_account_message_t n2c_account_message;
  logic                  n2c_mes_service_consumed;
  logic                  network_available;
  logic                  c2n_release_valid;
  sync_release_message_t c2n_release_message;
  tile_mask_t            c2n_release_destination_valid;

  modport master (
    input  n2c_account_valid,
    input  n2c_account_message,
    input  network_available,
    output n2c_mes_service_consumed,
    output c2n_release_valid,
    output c2n_release_message,
    output c2n_release_destination_valid
  );

  modport slave (
    output n2c_account_valid,
    output n2c_account_message,
    output network_available,
    input  n2c_mes_service_consumed,
    input  c2n_release_valid,
    input  c2n_release_message,
    input  c2n_release_destination_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: registered-occupancy FIFO, push+pop allowed together even when full.
// Ports: clk, reset (async low), i_push/i_data, i_pop/o_data, o_empty, o_full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (i_pop)
        r_rptr <= r_rptr + PW'(1);
      if (i_push && !i_pop)
        r_cnt <= r_cnt + (PW+1)'(1);
      else if (!i_push && i_pop)
        r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
endmodule

// File: rtl/barrier_master.sv
// barrier_master: counts ACCOUNTs per barrier ID, queues and multicasts RELEASEs.
// Ports: clk, reset (async low), bus (barrier_master_if.master), bm_error.
// Optional checking via BARRIER_MASTER_CHECK_EN (DISPLAY_SYNC adds a message).
module barrier_master
  import barrier_master_pkg::*;
#(
  parameter int TILE_ID        = 0,
  parameter int BARRIER_NUMB   = `BARRIER_NUMB_FOR_TILE,
  parameter int REL_FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  barrier_master_if.master bus,
  output logic             bm_error
);
  localparam int IDX_W = $clog2(BARRIER_NUMB);

  barrier_master_entry_t r_tbl [BARRIER_NUMB];

  sync_account_message_t w_msg;
  logic [IDX_W-1:0]      w_idx;
  barrier_master_entry_t w_cur;
  barrier_master_entry_t w_nxt;
  tile_mask_t            w_oh;
  logic                  w_acc;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  release_fifo_entry_t   w_push_d;
  release_fifo_entry_t   w_head;
  logic                  w_unused;

  assign w_msg = bus.n2c_account_message;
  assign w_idx = w_msg.id_barrier[IDX_W-1:0];
  assign w_cur = r_tbl[w_idx];
  assign w_oh  = idx_to_oh(w_msg.tile_id_source);
  assign w_acc = bus.n2c_account_valid & ~w_full;

  assign w_unused = TILE_ID[0];

  always_comb begin
    w_nxt    = w_cur;
    w_push   = 1'b0;
    w_push_d = '{id_barrier: w_msg.id_barrier,
                 tile_mask:  w_cur.tile_mask | w_oh};
    if (!w_cur.active) begin
      if (w_msg.cnt_setup == '0) begin
        // single-participant barrier completes without touching the table
        w_push             = w_acc;
        w_push_d.tile_mask = w_oh;
      end else begin
        w_nxt.active    = 1'b1;
        w_nxt.remaining = w_msg.cnt_setup - cnt_barrier_t'(1);
        w_nxt.tile_mask = w_oh;
`ifdef BARRIER_MASTER_CHECK_EN
        w_nxt.setup     = w_msg.cnt_setup;
`endif
      end
    end else if (w_cur.remaining != '0) begin
      w_nxt.remaining = w_cur.remaining - cnt_barrier_t'(1);
      w_nxt.tile_mask = w_cur.tile_mask | w_oh;
    end else begin
      w_push = w_acc;
      w_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BARRIER_NUMB; i++)
        r_tbl[i] <= '0;
    end else if (w_acc) begin
      r_tbl[w_idx] <= w_nxt;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(release_fifo_entry_t)),
    .DEPTH (REL_FIFO_DEPTH)
  ) u_rel_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_d),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_pop = ~w_empty & bus.network_available;

  assign bus.n2c_mes_service_consumed      = w_acc;
  assign bus.c2n_release_valid             = w_pop;
  assign bus.c2n_release_message           = '{id_barrier: w_head.id_barrier};
  assign bus.c2n_release_destination_valid = w_head.tile_mask;

`ifdef BARRIER_MASTER_CHECK_EN
  logic r_err;
  logic w_err;
  logic w_dup;

  // a repeated tile is only suspicious when every thread fits one per tile
  assign w_dup = ((w_cur.tile_mask & w_oh) != '0) &&
                 (int'(w_cur.setup) + 1 <= TILE_COUNT);
  assign w_err = w_acc & w_cur.active &
                 ((w_msg.cnt_setup != w_cur.setup) | w_dup);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else if (w_err) begin
      r_err <= 1'b1;
`ifdef DISPLAY_SYNC
      $display("barrier_master tile %0d: protocol error id %0d",
               TILE_ID, w_msg.id_barrier);
`endif
    end
  end

  assign bm_error = r_err;
`else
  assign bm_error = 1'b0;
`endif
endmodule

// File: tb/tb_barrier_master.sv
// tb_barrier_master: directed scenarios plus randomized run vs arrival-count model.
// Drives barrier_master_if from the NI side, samples on the falling edge.
module tb_barrier_master;
  import barrier_master_pkg::*;

  logic clk;
  logic reset;
  logic bm_error;
  int   errors;
  int   checks;

  logic     s_acc;
  logic     s_rv;
  barrier_t s_id;
  logic [3:0] s_mask;
  logic     s_err;

  barrier_master_if bus ();

  barrier_master dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .bm_error (bm_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    s_acc  = bus.n2c_mes_service_consumed;
    s_rv   = bus.c2n_release_valid;
    s_id   = bus.c2n_release_message.id_barrier;
    s_mask = bus.c2n_release_destination_valid;
    s_err  = bm_error;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int src,
                       input int id, input int st);
    bus.n2c_account_valid = v;
    bus.n2c_account_message = '{tile_id_source: tile_id_t'(src),
                                id_barrier: barrier_t'(id),
                                cnt_setup: cnt_barrier_t'(st)};
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 0);
    bus.network_available = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({s_acc, s_rv, s_id, s_mask, s_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got acc=%b rv=%b id=%0d mask=%b err=%b required all 0",
               s_acc, s_rv, s_id, s_mask, s_err);
    end
    reset = 1'b1;
    bus.network_available = 1'b1;
    tick();
    checks++;
    if (s_rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_release got rv=%b required 0", s_rv);
    end
  endtask

  task automatic test_full_barrier();
    do_reset();
    bus.network_available = 1'b1;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, t, 5, 3);
      tick();
      checks++;
      if (s_acc !== 1'b1 || s_rv !== 1'b0) begin
        errors++;
        $display("FAIL full_accept%0d got acc=%b rv=%b required acc=1 rv=0",
                 t, s_acc, s_rv);
      end
    end
    drive(1'b0, 0, 0, 0);
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_id !== 8'd5 || s_mask !== 4'b1111) begin
      errors++;
      $display("FAIL full_release got rv=%b id=%0d mask=%b required rv=1 id=5 mask=1111",
               s_rv, s_id, s_mask);
    end
    tick();
    checks++;
    if (s_rv !== 1'b0) begin
      errors++;
      $display("FAIL full_single got rv=%b required 0", s_rv);
    end
  endtask

  task automatic test_immediate();
    do_reset();
    bus.network_available = 1'b1;
    drive(1'b1, 1, 2, 0);
    tick();
    drive(1'b1, 3, 2, 0);
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_id !== 8'd2 || s_mask !== 4'b0010) begin
      errors++;
      $display("FAIL imm_release got rv=%b id=%0d mask=%b required rv=1 id=2 mask=0010",
               s_rv, s_id, s_mask);
    end
    drive(1'b0, 0, 0, 0);
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_id !== 8'd2 || s_mask !== 4'b1000) begin
      errors++;
      $display("FAIL imm_inactive got rv=%b id=%0d mask=%b required rv=1 id=2 mask=1000",
               s_rv, s_id, s_mask);
    end
  endtask

  task automatic test_interleave();
    int src_t [5] = '{0, 1, 2, 1, 3};
    int id_t  [5] = '{1, 3, 1, 3, 3};
    int st_t  [5] = '{1, 2, 1, 2, 2};
    logic [11:0] seen [$];
    do_reset();
    bus.network_available = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) drive(1'b1, src_t[c], id_t[c], st_t[c]);
      else drive(1'b0, 0, 0, 0);
      tick();
      if (s_rv === 1'b1) seen.push_back({s_id, s_mask});
    end
    checks++;
    if (seen.size() != 2) begin
      errors++;
      $display("FAIL inter_count got %0d required 2", seen.size());
    end else begin
      checks++;
      if (seen[0] !== {8'd1, 4'b0101} || seen[1] !== {8'd3, 4'b1010}) begin
        errors++;
        $display("FAIL inter_order got %h,%h required 015,03a", seen[0], seen[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_m;
    do_reset();
    bus.network_available = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, t, t, 0);
      tick();
      checks++;
      if (s_acc !== 1'b1 || s_rv !== 1'b0) begin
        errors++;
        $display("FAIL bp_fill%0d got acc=%b rv=%b required acc=1 rv=0",
                 t, s_acc, s_rv);
      end
    end
    drive(1'b1, 0, 4, 0);
    tick();
    checks++;
    if (s_acc !== 1'b0) begin
      errors++;
      $display("FAIL bp_blocked got acc=%b required 0", s_acc);
    end
    bus.network_available = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 1) drive(1'b0, 0, 0, 0);
      checks++;
      if (s_acc !== (c == 1)) begin
        errors++;
        $display("FAIL bp_acc%0d got %b required %b", c, s_acc, c == 1);
      end
      exp_m = (c < 4) ? 4'(1 << c) : 4'b0001;
      checks++;
      if (c < 5 && (s_rv !== 1'b1 || s_id !== 8'(c) || s_mask !== exp_m)) begin
        errors++;
        $display("FAIL bp_drain%0d got rv=%b id=%0d mask=%b required rv=1 id=%0d mask=%b",
                 c, s_rv, s_id, s_mask, c, exp_m);
      end else if (c == 5 && s_rv !== 1'b0) begin
        errors++;
        $display("FAIL bp_empty got rv=%b required 0", s_rv);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.network_available = 1'b1;
    drive(1'b1, 0, 7, 3);
    tick();
    drive(1'b1, 1, 7, 3);
    tick();
    drive(1'b0, 0, 0, 0);
    reset = 1'b0;
    tick();
    checks++;
    if ({s_acc, s_rv, s_id, s_mask, s_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset got acc=%b rv=%b id=%0d mask=%b err=%b required all 0",
               s_acc, s_rv, s_id, s_mask, s_err);
    end
    reset = 1'b1;
    drive(1'b1, 2, 7, 0);
    tick();
    drive(1'b0, 0, 0, 0);
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_id !== 8'd7 || s_mask !== 4'b0100) begin
      errors++;
      $display("FAIL mid_restart got rv=%b id=%0d mask=%b required rv=1 id=7 mask=0100",
               s_rv, s_id, s_mask);
    end
  endtask

  task automatic test_check();
    logic exp_e;
`ifdef BARRIER_MASTER_CHECK_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    do_reset();
    bus.network_available = 1'b1;
    drive(1'b1, 0, 4, 3);
    tick();
    drive(1'b1, 1, 4, 2);
    tick();
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_early got %b required 0", s_err);
    end
    drive(1'b0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_err !== exp_e) begin
        errors++;
        $display("FAIL chk_err%0d got %b required %b", c, s_err, exp_e);
      end
    end
  endtask

  task automatic test_random();
    int m_cnt [8];
    int m_setup [8];
    logic [3:0] m_mask [8];
    logic [7:0] q_id [$];
    logic [3:0] q_mask [$];
    logic v, na, exp_acc, exp_rv;
    int id, src, st;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0; m_setup[i] = 0; m_mask[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      na  = ($urandom_range(0, 9) < 6);
      id  = $urandom_range(0, 7);
      src = $urandom_range(0, 3);
      st  = (m_cnt[id] != 0) ? m_setup[id] : $urandom_range(0, 3);
      drive(v, src, id, st);
      bus.network_available = na;
      exp_acc = v && (q_id.size() < 4);
      exp_rv  = na && (q_id.size() > 0);
      tick();
      checks++;
      if (s_acc !== exp_acc || s_rv !== exp_rv) begin
        errors++;
        $display("FAIL rnd_hs%0d got acc=%b rv=%b required acc=%b rv=%b",
                 c, s_acc, s_rv, exp_acc, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (s_id !== q_id[0] || s_mask !== q_mask[0]) begin
          errors++;
          $display("FAIL rnd_rel%0d got id=%0d mask=%b required id=%0d mask=%b",
                   c, s_id, s_mask, q_id[0], q_mask[0]);
        end
        void'(q_id.pop_front());
        void'(q_mask.pop_front());
      end
      if (exp_acc) begin
        if (m_cnt[id] == 0) begin
          m_setup[id] = st;
          m_mask[id]  = '0;
        end
        m_cnt[id]++;
        m_mask[id] |= 4'(1 << src);
        if (m_cnt[id] == m_setup[id] + 1) begin
          q_id.push_back(8'(id));
          q_mask.push_back(m_mask[id]);
          m_cnt[id] = 0;
        end
      end
    end
    drive(1'b0, 0, 0, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive(1'b0, 0, 0, 0);
    bus.network_available = 1'b0;
    test_reset();
    test_full_barrier();
    test_immediate();
    test_interleave();
    test_backpressure();
    test_reset_mid();
    test_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
